// File: rtl/vec_elem_sequencer_pkg.sv
// Shared types and default widths for the vector element sequencer and its operand queues.
package vec_elem_sequencer_pkg;

    localparam int DEF_NUM_LANES  = 4;
    localparam int DEF_ELEM_WIDTH = 64;
    localparam int DEF_MAX_VLEN   = 64;
    localparam int DEF_OPQ_DEPTH  = 4;
    localparam int DEF_REG_PTR_W  = 5;
    localparam int DEF_FUNC_OP_W  = 4;

    typedef enum logic [DEF_FUNC_OP_W-1:0] {
        SADD = 4'd0,
        SSUB = 4'd1,
        SMUL = 4'd2,
        SDIV = 4'd3,
        SAND = 4'd4,
        SOR  = 4'd5,
        SXOR = 4'd6,
        SMIN = 4'd7,
        SMAX = 4'd8
    } func_opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/vec_elem_sequencer_fifo.sv
// Small synchronous FIFO holding one register-file port's returned operands until they can be paired.
module operand_fifo
    import vec_elem_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_ELEM_WIDTH,
    parameter int DEPTH = DEF_OPQ_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Streams one vector instruction's element reads from two RF ports, pairs operands and
// dispatches each enabled element to the lowest free functional lane.
module vec_elem_sequencer
    import vec_elem_sequencer_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int MAX_VLEN   = DEF_MAX_VLEN,
    parameter int OPQ_DEPTH  = DEF_OPQ_DEPTH,
    parameter int REG_PTR_W  = DEF_REG_PTR_W,
    parameter int FUNC_OP_W  = DEF_FUNC_OP_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_inst_vld,
    output logic                             o_inst_rdy,
    input  logic [FUNC_OP_W-1:0]             i_inst_op,
    input  logic [REG_PTR_W-1:0]             i_inst_src0,
    input  logic [REG_PTR_W-1:0]             i_inst_src1,
    input  logic [REG_PTR_W-1:0]             i_inst_dst,
    input  logic [$clog2(MAX_VLEN+1)-1:0]    i_inst_vlen,
    input  logic [MAX_VLEN-1:0]              i_inst_mask,
    output logic                             o_rd0_req_vld,
    input  logic                             i_rd0_req_gnt,
    output logic [REG_PTR_W-1:0]             o_rd0_req_reg,
    output logic [$clog2(MAX_VLEN)-1:0]      o_rd0_req_idx,
    input  logic                             i_rd0_rsp_vld,
    input  logic [ELEM_WIDTH-1:0]            i_rd0_rsp_data,
    output logic                             o_rd1_req_vld,
    input  logic                             i_rd1_req_gnt,
    output logic [REG_PTR_W-1:0]             o_rd1_req_reg,
    output logic [$clog2(MAX_VLEN)-1:0]      o_rd1_req_idx,
    input  logic                             i_rd1_rsp_vld,
    input  logic [ELEM_WIDTH-1:0]            i_rd1_rsp_data,
    input  logic [NUM_LANES-1:0]             i_lane_busy,
    output logic [NUM_LANES-1:0]             o_lane_vld,
    output logic [FUNC_OP_W-1:0]             o_lane_op,
    output logic [ELEM_WIDTH-1:0]            o_lane_data0,
    output logic [ELEM_WIDTH-1:0]            o_lane_data1,
    output logic [REG_PTR_W-1:0]             o_lane_dst,
    output logic [$clog2(MAX_VLEN)-1:0]      o_lane_idx,
    output logic                             o_done,
    output logic                             o_active
);

    localparam int VLEN_W = $clog2(MAX_VLEN + 1);
    localparam int IDX_W  = $clog2(MAX_VLEN);
    localparam int CRED_W = $clog2(OPQ_DEPTH + 1);

    seq_state_t            r_state, w_state_nxt;
    logic [FUNC_OP_W-1:0]  r_op;
    logic [REG_PTR_W-1:0]  r_src0, r_src1, r_dst;
    logic [VLEN_W-1:0]     r_vlen, r_retire_idx;
    logic [MAX_VLEN-1:0]   r_mask;
    logic                  r_done_zero;

    logic                  w_accept, w_run, w_heads_vld, w_elem_en, w_lane_free, w_pop, w_dispatch;
    logic [NUM_LANES-1:0]  w_lane_onehot;
    logic [1:0]            w_req_vld, w_gnt, w_rsp_vld, w_push, w_empty, w_full;
    logic [ELEM_WIDTH-1:0] w_rsp_data [2];
    logic [ELEM_WIDTH-1:0] w_head     [2];
    logic [IDX_W-1:0]      w_req_idx  [2];

    assign w_accept      = (r_state == IDLE) && i_inst_vld;
    assign w_run         = (r_state == RUN);
    assign w_gnt         = {i_rd1_req_gnt, i_rd0_req_gnt};
    assign w_rsp_vld     = {i_rd1_rsp_vld, i_rd0_rsp_vld};
    assign w_rsp_data[0] = i_rd0_rsp_data;
    assign w_rsp_data[1] = i_rd1_rsp_data;

    // Credit covers queue slots plus requests in flight, so a queue can never overflow.
    // Responses with nothing outstanding belong to an instruction killed by reset.
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [VLEN_W-1:0] r_req_idx;
        logic [CRED_W-1:0] r_credit;
        logic [CRED_W-1:0] r_outst;
        logic              w_grant;

        assign w_req_vld[p] = w_run && (r_req_idx < r_vlen) && (r_credit != '0);
        assign w_grant      = w_req_vld[p] && w_gnt[p];
        assign w_push[p]    = w_rsp_vld[p] && (r_outst != '0);
        assign w_req_idx[p] = r_req_idx[IDX_W-1:0];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_req_idx <= '0;
                r_credit  <= CRED_W'(OPQ_DEPTH);
                r_outst   <= '0;
            end else begin
                if (w_accept)     r_req_idx <= '0;
                else if (w_grant) r_req_idx <= r_req_idx + VLEN_W'(1);
                r_credit <= r_credit - CRED_W'(w_grant) + CRED_W'(w_pop);
                r_outst  <= r_outst + CRED_W'(w_grant) - CRED_W'(w_push[p]);
            end
        end

        operand_fifo #(.WIDTH(ELEM_WIDTH), .DEPTH(OPQ_DEPTH)) u_opq (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[p]),
            .i_data  (w_rsp_data[p]),
            .i_pop   (w_pop),
            .o_data  (w_head[p]),
            .o_empty (w_empty[p]),
            .o_full  (w_full[p])
        );

        a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
            !(w_push[p] && w_full[p] && !w_pop));
    end

    assign o_rd0_req_vld = w_req_vld[0];
    assign o_rd1_req_vld = w_req_vld[1];
    assign o_rd0_req_reg = r_src0;
    assign o_rd1_req_reg = r_src1;
    assign o_rd0_req_idx = w_req_idx[0];
    assign o_rd1_req_idx = w_req_idx[1];

    // Lowest-indexed free lane wins.
    always_comb begin
        w_lane_onehot = '0;
        w_lane_free   = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (!i_lane_busy[i]) begin
                w_lane_onehot    = '0;
                w_lane_onehot[i] = 1'b1;
                w_lane_free      = 1'b1;
            end
        end
    end

    assign w_heads_vld = w_run && !w_empty[0] && !w_empty[1];
    assign w_elem_en   = r_mask[r_retire_idx[IDX_W-1:0]];
    assign w_pop       = w_heads_vld && (!w_elem_en || w_lane_free);
    assign w_dispatch  = w_heads_vld && w_elem_en && w_lane_free;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_src0       <= '0;
            r_src1       <= '0;
            r_dst        <= '0;
            r_vlen       <= '0;
            r_mask       <= '0;
            r_retire_idx <= '0;
            r_done_zero  <= 1'b0;
            o_lane_vld   <= '0;
            o_lane_op    <= '0;
            o_lane_data0 <= '0;
            o_lane_data1 <= '0;
            o_lane_dst   <= '0;
            o_lane_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_zero <= w_accept && (i_inst_vlen == '0);
            if (w_accept) begin
                r_op         <= i_inst_op;
                r_src0       <= i_inst_src0;
                r_src1       <= i_inst_src1;
                r_dst        <= i_inst_dst;
                r_vlen       <= i_inst_vlen;
                r_mask       <= i_inst_mask;
                r_retire_idx <= '0;
            end else if (w_pop) begin
                r_retire_idx <= r_retire_idx + VLEN_W'(1);
            end
            o_lane_vld <= w_dispatch ? w_lane_onehot : '0;
            if (w_dispatch) begin
                o_lane_op    <= r_op;
                o_lane_data0 <= w_head[0];
                o_lane_data1 <= w_head[1];
                o_lane_dst   <= r_dst;
                o_lane_idx   <= r_retire_idx[IDX_W-1:0];
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        o_inst_rdy  = 1'b0;
        o_active    = 1'b0;
        o_done      = r_done_zero;
        unique case (r_state)
            IDLE: begin
                o_inst_rdy = 1'b1;
                if (i_inst_vld && (i_inst_vlen != '0)) w_state_nxt = RUN;
            end
            RUN: begin
                o_active = 1'b1;
                if (r_retire_idx == r_vlen) w_state_nxt = DONE;
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
